// File: rtl/sobel_window_gen.sv
// Streaming 3x3 Sobel window generator: buffers two image rows and emits the
// six non-centre-row neighbours of every interior pixel in raster order.
module sobel_window_gen #(
    parameter int SRC_ROWS = 3,
    parameter int SRC_COLS = 4,
    parameter int PIX_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PIX_W-1:0] in_pixel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [PIX_W-1:0] z1,
    output logic [PIX_W-1:0] z2,
    output logic [PIX_W-1:0] z3,
    output logic [PIX_W-1:0] z4,
    output logic [PIX_W-1:0] z5,
    output logic [PIX_W-1:0] z6,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             frame_done
);

    localparam int ROW_W = $clog2(SRC_ROWS);
    localparam int COL_W = $clog2(SRC_COLS);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SRC_ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(SRC_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);

    logic [ROW_W-1:0] row_p0;
    logic [COL_W-1:0] col_p0;
    logic [PIX_W-1:0] top_buf [SRC_COLS];
    logic [PIX_W-1:0] mid_buf [SRC_COLS];
    logic [PIX_W-1:0] top_rd_p0;
    logic             acc_p0;
    logic             emit_p0;
    logic             last_pos_p0;

    logic [PIX_W-1:0] a_sh_p1 [3];
    logic [PIX_W-1:0] b_sh_p1 [3];
    logic             vld_p1;
    logic             last_p1;
    logic             done_p2;

    // Stage p0: pixel accept, position decode, line-buffer read
    assign in_ready    = !vld_p1 || out_ready;
    assign acc_p0      = in_valid && in_ready;
    assign top_rd_p0   = top_buf[col_p0];
    assign emit_p0     = (row_p0 >= ROW_TWO) && (col_p0 >= COL_TWO);
    assign last_pos_p0 = (row_p0 == ROW_LAST) && (col_p0 == COL_LAST);

    always_ff @(posedge clk) begin
        if (reset && acc_p0) begin
            top_buf[col_p0] <= mid_buf[col_p0];
            mid_buf[col_p0] <= in_pixel;
        end
    end

    // Stage p1: the shift registers double as the output window register;
    // they only move on an accept, so they hold steady under backpressure.
    always_ff @(posedge clk) begin
        if (!reset) begin
            row_p0     <= '0;
            col_p0     <= '0;
            vld_p1     <= 1'b0;
            last_p1    <= 1'b0;
            done_p2    <= 1'b0;
            a_sh_p1[0] <= '0;
            a_sh_p1[1] <= '0;
            a_sh_p1[2] <= '0;
            b_sh_p1[0] <= '0;
            b_sh_p1[1] <= '0;
            b_sh_p1[2] <= '0;
        end else begin
            done_p2 <= vld_p1 && out_ready && last_p1;
            if (acc_p0) begin
                if (col_p0 == COL_LAST) begin
                    col_p0 <= '0;
                    row_p0 <= (row_p0 == ROW_LAST) ? '0 : row_p0 + 1'b1;
                end else begin
                    col_p0 <= col_p0 + 1'b1;
                end
                a_sh_p1[0] <= top_rd_p0;
                a_sh_p1[1] <= a_sh_p1[0];
                a_sh_p1[2] <= a_sh_p1[1];
                b_sh_p1[0] <= in_pixel;
                b_sh_p1[1] <= b_sh_p1[0];
                b_sh_p1[2] <= b_sh_p1[1];
                vld_p1     <= emit_p0;
                last_p1    <= emit_p0 && last_pos_p0;
            end else if (out_ready) begin
                vld_p1  <= 1'b0;
                last_p1 <= 1'b0;
            end
        end
    end

    // Stage p2: frame completion pulse
    assign z1         = a_sh_p1[2];
    assign z2         = a_sh_p1[1];
    assign z3         = a_sh_p1[0];
    assign z4         = b_sh_p1[2];
    assign z5         = b_sh_p1[1];
    assign z6         = b_sh_p1[0];
    assign out_valid  = vld_p1;
    assign out_last   = last_p1;
    assign frame_done = done_p2;

endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Streaming window generator for the deterministic Sobel datapath. Accepts a raster-order 8-bit pixel stream, one frame of SRC_ROWS × SRC_COLS pixels, and buffers two image rows. For every interior pixel it emits the six neighbours consumed by `sobel3x3det`: three from the row above and three from the row below. Windows leave in the same row-major order used for software-generated reference edge files, so outputs compare directly against them.

## Interface
- SRC_ROWS, 3, image height in pixels; must be ≥ 3
- SRC_COLS, 4, image width in pixels; must be ≥ 3
- PIX_W, 8, pixel width in bits
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (asserted when 0)
- in_pixel  input  PIX_W  raster pixel, row-major, top-left first
- in_valid  input  1  in_pixel is valid
- in_ready  output  1  block accepts in_pixel this cycle
- z1, z2, z3  output  PIX_W each  row above the window centre, columns c-1, c, c+1
- z4, z5, z6  output  PIX_W each  row below the window centre, columns c-1, c, c+1
- out_valid  output  1  z1..z6 hold a valid window
- out_ready  input  1  consumer takes the window this cycle
- out_last  output  1  qualifies out_valid; set on the final window of the frame
- frame_done  output  1  one-cycle pulse when the final window is accepted

## Operation
- Pixel accept: `in_valid && in_ready`. Window accept: `out_valid && out_ready`.
- Counters:
  - col: 0..SRC_COLS-1, advances on each pixel accept.
  - row: 0..SRC_ROWS-1, advances when col wraps from SRC_COLS-1 to 0.
  - row wraps from SRC_ROWS-1 to 0 at end of frame, so the next frame starts without a reset.
- Line buffers:
  - Two arrays of SRC_COLS pixels each: `top` holds row r-2 and `mid` holds row r-1.
  - On accepting pixel p at (r,c), write `top[c] <= mid[c]` and `mid[c] <= p` in the same cycle.
- Shift registers:
  - A 3-deep register `a_sh` shifts in the pre-update `top[c]`.
  - A 3-deep register `b_sh` shifts in p.
  - Neither register is cleared at row start; the emit condition below masks their stale contents.
- Emit condition: an accept at r ≥ 2 and c ≥ 2 produces the window centred at (r-1, c-1):
  - z1 = src[r-2][c-2], z2 = src[r-2][c-1], z3 = src[r-2][c]
  - z4 = src[r][c-2], z5 = src[r][c-1], z6 = src[r][c]
- Window count: each frame emits exactly (SRC_ROWS-2)·(SRC_COLS-2) windows. out_last is set on the window produced by the accept at (SRC_ROWS-1, SRC_COLS-1).
- Output register: a single-entry output register holds z1..z6, out_valid and out_last.
  - in_ready = !out_valid || out_ready, so an accept and a window hand-off can occur in the same cycle with no bubble.
- Backpressure: while out_valid && !out_ready:
  - in_ready is 0.
  - z1..z6 and out_last hold stable.
  - Counters and buffers do not change.
- Upstream protocol: in_pixel must be held stable while in_valid && !in_ready.
- frame_done rises in the cycle after the window with out_last is accepted, and lasts one cycle.
- Reset:
  - row = col = 0.
  - out_valid = 0, out_last = 0, frame_done = 0.
  - z1..z6 = 0, both shift registers = 0.
  - in_ready = 1 from the first cycle after reset.
  - Line-buffer contents are not cleared; every location is rewritten before it is read.
- Reset mid-frame: discard the partial frame and any pending window. The next accepted pixel is (0,0).

## Timing
- Latency: pixel accept at cycle t gives out_valid = 1 at t+1, when the emit condition holds.
- Throughput: one pixel per cycle with out_ready held at 1.
  - Windows appear in every cycle whose preceding accept satisfied the emit condition.
  - out_valid is 0 during the column-0/1 accepts and during rows 0 and 1.
- Gaps in in_valid insert bubbles only. Window content and order do not depend on gaps.
- No combinational path from in_valid to any output. in_ready depends combinationally on out_ready only.

## Test plan
- Default 3×4 frame, pixels 0x00..0x0B in order, out_ready = 1:
  - First window is z1..z6 = 00, 01, 02, 08, 09, 0A, with out_last = 0.
  - Second window is 01, 02, 03, 09, 0A, 0B, with out_last = 1.
  - frame_done pulses once, the cycle after the second window.
- Same frame with out_ready = 0 for 5 cycles after the first window:
  - in_ready stays 0 and z1..z6 hold 00, 01, 02, 08, 09, 0A.
  - No pixel is lost, and the second window matches the previous scenario.
- Random in_valid gaps (~50% duty) on a 5×6 frame with pixel value = 6·r + c:
  - 12 windows, all matching the emit-condition equations.
  - out_last is set only on the 12th window.
- Two back-to-back 3×4 frames with no reset between them: the second frame yields identical windows, and frame_done pulses twice.
- Reset = 0 for one cycle after 7 pixels of a 3×4 frame, then a full fresh frame:
  - out_valid is 0 the cycle after reset.
  - The fresh frame yields exactly the two windows of the first scenario.
- Hold reset = 0 with in_valid = 1: all outputs stay 0, and no pixel is counted.
